// File: rtl/fp_div_result_stage_if.sv
// Handshake bundle between the NR divider, the result stage and the result consumer.
// A transfer happens on a rising edge where valid && ready; data is held while valid && !ready.
interface fp_div_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [31:0] quotient;
    logic        div_exception;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, a_operand, b_operand, quotient, div_exception, out_ready,
        input  in_ready, out_valid, result, out_flags
    );

    modport slave (
        input  in_valid, a_operand, b_operand, quotient, div_exception, out_ready,
        output in_ready, out_valid, result, out_flags
    );
endinterface

// File: rtl/fp_div_result_stage.sv
// Two-stage result stage after the NR divider: patches in IEEE special values and exponent
// overflow/underflow, and keeps sticky flags plus a completed-operation counter.
module fp_div_result_stage #(
    parameter logic [31:0] QNAN  = 32'h7FC0_0000,
    parameter int          CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_div_result_stage_if.slave io,
    input  logic                 flag_clear,
    output logic [3:0]           sticky_flags,
    output logic [CNT_W-1:0]     op_count
);
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    function automatic op_class_t classify(input logic [31:0] x);
        op_class_t c;
        c = CLS_NORMAL;
        if (x[30:23] == 8'hFF) begin
            c = (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (x[30:23] == 8'h00) begin
            c = CLS_ZERO;
        end
        return c;
    endfunction

    // div_exception and the quotient's sign/exponent duplicate what the operand classes and
    // exp_est already give us, so they are deliberately not consumed.
    logic unused_inputs;
    assign unused_inputs = ^{io.div_exception, io.quotient[31:23]};

    logic              s1_valid;
    logic              s1_sign;
    op_class_t         s1_a_cls;
    op_class_t         s1_b_cls;
    logic signed [9:0] s1_exp;
    logic [22:0]       s1_man;

    logic              s2_valid;
    logic [31:0]       result_q;
    logic [3:0]        flags_q;

    logic              s2_adv;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic signed [9:0] exp_next;
    logic [31:0]       sel_result;
    logic [3:0]        sel_flags;

    assign s2_adv   = !s2_valid || io.out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = io.in_valid && in_ready;
    assign out_fire = s2_valid && io.out_ready;

    assign io.in_ready  = in_ready;
    assign io.out_valid = s2_valid;
    assign io.result    = result_q;
    assign io.out_flags = flags_q;

    // Implicit leading ones cancel, so only the fraction compare decides the renormalising borrow.
    always_comb begin
        exp_next = $signed({2'b00, io.a_operand[30:23]}) - $signed({2'b00, io.b_operand[30:23]})
                 + 10'sd127
                 - ((io.a_operand[22:0] < io.b_operand[22:0]) ? 10'sd1 : 10'sd0);
    end

    // Flags are {invalid, div_by_zero, overflow, underflow}.
    always_comb begin
        sel_result = {s1_sign, s1_exp[7:0], s1_man};
        sel_flags  = 4'b0000;
        if (s1_a_cls == CLS_NAN || s1_b_cls == CLS_NAN) begin
            sel_result = QNAN;
            sel_flags  = 4'b1000;
        end else if ((s1_a_cls == CLS_INF && s1_b_cls == CLS_INF) ||
                     (s1_a_cls == CLS_ZERO && s1_b_cls == CLS_ZERO)) begin
            sel_result = QNAN;
            sel_flags  = 4'b1000;
        end else if (s1_a_cls == CLS_INF) begin
            sel_result = {s1_sign, 8'hFF, 23'd0};
        end else if (s1_b_cls == CLS_INF) begin
            sel_result = {s1_sign, 31'd0};
        end else if (s1_b_cls == CLS_ZERO) begin
            sel_result = {s1_sign, 8'hFF, 23'd0};
            sel_flags  = 4'b0100;
        end else if (s1_a_cls == CLS_ZERO) begin
            sel_result = {s1_sign, 31'd0};
        end else if (s1_exp >= 10'sd255) begin
            sel_result = {s1_sign, 8'hFF, 23'd0};
            sel_flags  = 4'b0010;
        end else if (s1_exp <= 10'sd0) begin
            sel_result = {s1_sign, 31'd0};
            sel_flags  = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            result_q     <= 32'd0;
            flags_q      <= 4'd0;
            sticky_flags <= 4'd0;
            op_count     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= io.in_valid;
            end
            if (in_fire) begin
                s1_sign  <= io.a_operand[31] ^ io.b_operand[31];
                s1_a_cls <= classify(io.a_operand);
                s1_b_cls <= classify(io.b_operand);
                s1_exp   <= exp_next;
                s1_man   <= io.quotient[22:0];
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result_q <= sel_result;
                    flags_q  <= sel_flags;
                end
            end
            // A clear wins over a same-cycle transfer; that transfer's flags are dropped.
            if (flag_clear) begin
                sticky_flags <= 4'd0;
            end else if (out_fire) begin
                sticky_flags <= sticky_flags | flags_q;
            end
            if (out_fire) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fp_div_result_stage.sv
// Self-checking bench for fp_div_result_stage: directed IEEE corner cases plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_fp_div_result_stage;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flag_clear = 1'b0;
    logic [3:0]  sticky_flags;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fp_div_result_stage_if io ();

    fp_div_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .io           (io),
        .flag_clear   (flag_clear),
        .sticky_flags (sticky_flags),
        .op_count     (op_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    logic [35:0] exp_q[$];
    int          cyc_q[$];
    logic [36:0] lit_q[$];
    logic [3:0]  m_sticky;
    logic [15:0] m_count;
    logic        cur_lit_v = 1'b0;
    logic [35:0] cur_lit = '0;
    logic        stable_v = 1'b0;
    logic [35:0] stable_val;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {flags, result} straight from the IEEE special-case rules, integer exponent math.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
        int   ea, eb, e;
        bit   an, ai, az, bn, bi, bz;
        logic s;
        logic [7:0] ee;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        az = (ea == 0);
        bn = (eb == 255) && (b[22:0] != 0);
        bi = (eb == 255) && (b[22:0] == 0);
        bz = (eb == 0);
        s  = a[31] ^ b[31];
        if (an || bn) return {4'b1000, QNAN};
        if ((ai && bi) || (az && bz)) return {4'b1000, QNAN};
        if (ai) return {4'b0000, s, 8'hFF, 23'd0};
        if (bi) return {4'b0000, s, 31'd0};
        if (bz) return {4'b0100, s, 8'hFF, 23'd0};
        if (az) return {4'b0000, s, 31'd0};
        e = ea - eb + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0001, s, 31'd0};
        ee = e[7:0];
        return {4'b0000, s, ee, q[22:0]};
    endfunction

    function automatic logic any_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (a[30:23] == 8'h00) ||
               (b[30:23] == 8'hFF) || (b[30:23] == 8'h00);
    endfunction

    function automatic logic [31:0] rand_operand();
        int   k;
        logic [7:0] e;
        logic [22:0] m;
        logic [7:0] edge_exps [7];
        edge_exps = '{8'd1, 8'd2, 8'd126, 8'd127, 8'd128, 8'd253, 8'd254};
        k = $urandom_range(0, 9);
        m = 23'($urandom);
        if (k == 0)      e = 8'h00;
        else if (k == 1) begin e = 8'hFF; m = 23'd0; end
        else if (k == 2) begin e = 8'hFF; m = m | 23'd1; end
        else if (k < 6)  e = edge_exps[$urandom_range(0, 6)];
        else             e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // Compare process: model state advances on the same edges the DUT sees.
    always @(negedge clk) begin : compare
        logic exp_v;
        if (rst) begin
            started  = 1'b1;
            exp_q.delete();
            cyc_q.delete();
            lit_q.delete();
            m_sticky = 4'd0;
            m_count  = 16'd0;
            stable_v = 1'b0;
        end else if (started) begin
            cyc++;
            chk("in_ready", io.in_ready, (exp_q.size() < 2) || io.out_ready);
            exp_v = (exp_q.size() > 0) && ((cyc - cyc_q[0]) >= 2);
            chk("out_valid", io.out_valid, exp_v);
            chk("op_count", op_count, m_count);
            chk("sticky_flags", sticky_flags, m_sticky);
            if (stable_v && io.out_valid)
                chk("stall_stable", {io.out_flags, io.result}, stable_val);
            stable_v   = io.out_valid && !io.out_ready;
            stable_val = {io.out_flags, io.result};
            if (exp_v && io.out_valid) begin
                chk("result", io.result, exp_q[0][31:0]);
                chk("out_flags", io.out_flags, exp_q[0][35:32]);
                if (lit_q[0][36]) chk("literal", {io.out_flags, io.result}, lit_q[0][35:0]);
            end
            if (flag_clear) m_sticky = 4'd0;
            else if (exp_v && io.out_ready) m_sticky = m_sticky | exp_q[0][35:32];
            if (exp_v && io.out_ready) begin
                m_count++;
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
                void'(lit_q.pop_front());
            end
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(model(io.a_operand, io.b_operand, io.quotient));
                cyc_q.push_back(cyc);
                lit_q.push_back({cur_lit_v, cur_lit});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic lv, input logic [35:0] lit);
        io.a_operand     = a;
        io.b_operand     = b;
        io.quotient      = q;
        io.div_exception = any_special(a, b);
        cur_lit_v        = lv;
        cur_lit          = lit;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic [35:0] lit);
        logic acc;
        acc = 1'b0;
        drive(a, b, q, 1'b1, lit);
        io.in_valid = 1'b1;
        for (int g = 0; g < 50 && !acc; g++) begin
            @(negedge clk);
            acc = io.in_ready;
            step();
        end
        chk("send_accept", acc, 1'b1);
        io.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 60; g++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain", exp_q.size() == 0, 1'b1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        io.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic [31:0] bp_r [4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  idx;
        logic acc;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 36'd0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_in_ready", io.in_ready, 1'b1);
        chk("rst_out_valid", io.out_valid, 1'b0);
        chk("rst_result", io.result, 32'd0);
        chk("rst_out_flags", io.out_flags, 4'd0);
        chk("rst_op_count", op_count, 16'd0);
        chk("rst_sticky", sticky_flags, 4'd0);

        // 6.0 / 2.0 with exact 2-cycle latency
        io.out_ready = 1'b1;
        send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, {4'b0000, 32'h4040_0000});
        chk("lat_s1", io.out_valid, 1'b0);
        step();
        chk("lat_s2", io.out_valid, 1'b1);
        chk("lat_result", io.result, 32'h4040_0000);
        wait_idle();
        chk("op_count_1", op_count, 16'd1);

        // Special values and exponent range
        send(32'h3F80_0000, 32'h0000_0000, 32'h1234_5678, {4'b0100, 32'h7F80_0000});
        send(32'hBF80_0000, 32'h0000_0000, 32'h1234_5678, {4'b0100, 32'hFF80_0000});
        send(32'h0000_0000, 32'h0000_0000, 32'h1234_5678, {4'b1000, 32'h7FC0_0000});
        send(32'h7FC0_0001, 32'h3F80_0000, 32'h1234_5678, {4'b1000, 32'h7FC0_0000});
        send(32'h7F00_0000, 32'h0080_0000, 32'h1234_5678, {4'b0010, 32'h7F80_0000});
        send(32'h0080_0000, 32'h7F00_0000, 32'h1234_5678, {4'b0001, 32'h0000_0000});
        wait_idle();
        chk("sticky_all", sticky_flags, 4'b1111);
        chk("op_count_7", op_count, 16'd7);
        flag_clear = 1'b1;
        step();
        flag_clear = 1'b0;
        chk("sticky_cleared", sticky_flags, 4'b0000);

        // Backpressure: four back-to-back inputs, consumer stalled for 5 cycles
        bp_a = '{32'h40C0_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000};
        bp_b = '{32'h4000_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000};
        bp_r = '{32'h4040_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3EAA_AAAB};
        reset_dut();
        io.out_ready = 1'b0;
        idx = 0;
        io.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(bp_a[idx], bp_b[idx], bp_r[idx], 1'b1, {4'b0000, bp_r[idx]});
            @(negedge clk);
            acc = io.in_ready;
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready_low", io.in_ready, 1'b0);
        io.out_ready = 1'b1;
        for (int g = 0; g < 20 && idx < 4; g++) begin
            drive(bp_a[idx], bp_b[idx], bp_r[idx], 1'b1, {4'b0000, bp_r[idx]});
            @(negedge clk);
            acc = io.in_ready;
            step();
            if (acc) idx++;
        end
        io.in_valid = 1'b0;
        chk("bp_all_sent", idx, 4);
        wait_idle();
        chk("bp_op_count", op_count, 16'd4);

        // Reset while two operations are in flight
        reset_dut();
        send(32'h3F80_0000, 32'h0000_0000, 32'h0, {4'b0100, 32'h7F80_0000});
        wait_idle();
        chk("pre_rst_sticky", sticky_flags, 4'b0100);
        chk("pre_rst_count", op_count, 16'd1);
        io.out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, {4'b0000, 32'h4040_0000});
        send(32'h7F00_0000, 32'h0080_0000, 32'h0, {4'b0010, 32'h7F80_0000});
        reset_dut();
        chk("mid_rst_out_valid", io.out_valid, 1'b0);
        chk("mid_rst_op_count", op_count, 16'd0);
        chk("mid_rst_sticky", sticky_flags, 4'd0);
        io.out_ready = 1'b1;
        repeat (10) step();
        chk("no_stale_result", io.out_valid, 1'b0);

        // Random traffic with random backpressure and occasional clears
        for (int c = 0; c < 3000; c++) begin
            drive(rand_operand(), rand_operand(), $urandom, 1'b0, 36'd0);
            io.in_valid  = ($urandom_range(0, 3) != 0);
            io.out_ready = ($urandom_range(0, 3) != 0);
            flag_clear   = ($urandom_range(0, 15) == 0);
            step();
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        flag_clear   = 1'b0;
        wait_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
